// File: rtl/is2vid_genlock_pkg.sv
// is2vid_genlock_pkg: shared states, widths and request decode for the genlock adjuster
package is2vid_genlock_pkg;

    localparam int GA_H_WIDTH    = 14;
    localparam int GA_V_WIDTH    = 13;
    localparam int GA_LOCK_WIDTH = 4;

    typedef enum logic [1:0] {
        GA_IDLE,
        GA_LOAD,
        GA_STALL_LINES,
        GA_STALL_SAMPLES
    } ga_state_t;

    typedef enum logic [1:0] {
        GA_REQ_NONE,
        GA_REQ_LOCKED,
        GA_REQ_LINES,
        GA_REQ_SAMPLES
    } ga_req_t;

    // Genlocked wins over any correction; line corrections win over sample-only ones.
    function automatic ga_req_t ga_decode(input logic genlocked, input logic lines, input logic samples);
        return genlocked ? GA_REQ_LOCKED : lines ? GA_REQ_LINES : samples ? GA_REQ_SAMPLES : GA_REQ_NONE;
    endfunction

endpackage

// File: rtl/is2vid_genlock_adjust_if.sv
// is2vid_genlock_adjust_if: comparator requests in, frame-counter controls out
interface is2vid_genlock_adjust_if
    import is2vid_genlock_pkg::*;
#(
    parameter int H_WIDTH = GA_H_WIDTH,
    parameter int V_WIDTH = GA_V_WIDTH
);
    logic               enable;
    logic               sof_cvo;
    logic [H_WIDTH-1:0] h_total_minus_one;
    logic               sync_lines;
    logic               sync_samples;
    logic               remove_repeatn;
    logic               genlocked;
    logic [H_WIDTH-1:0] sync_compare_h_reset;
    logic [V_WIDTH-1:0] sync_compare_v_reset;
    logic               cnt_enable;
    logic               cnt_load;
    logic [H_WIDTH-1:0] cnt_h_reset;
    logic [V_WIDTH-1:0] cnt_v_reset;
    logic               adjusting;
    logic               genlock_locked;

    modport master (
        output enable, sof_cvo, h_total_minus_one, sync_lines, sync_samples, remove_repeatn,
               genlocked, sync_compare_h_reset, sync_compare_v_reset,
        input  cnt_enable, cnt_load, cnt_h_reset, cnt_v_reset, adjusting, genlock_locked
    );

    modport slave (
        input  enable, sof_cvo, h_total_minus_one, sync_lines, sync_samples, remove_repeatn,
               genlocked, sync_compare_h_reset, sync_compare_v_reset,
        output cnt_enable, cnt_load, cnt_h_reset, cnt_v_reset, adjusting, genlock_locked
    );

endinterface

// File: rtl/is2vid_stall_counter.sv
// is2vid_stall_counter: nested line/sample counters timing one repeat stall
module is2vid_stall_counter
    import is2vid_genlock_pkg::*;
#(
    parameter int H_WIDTH = GA_H_WIDTH,
    parameter int V_WIDTH = GA_V_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               abort,
    input  logic               load,
    input  logic [V_WIDTH-1:0] lines,
    input  logic [H_WIDTH-1:0] samples,
    input  logic [H_WIDTH-1:0] htot,
    output logic               busy,
    output logic               lines_done,
    output logic               done
);
    ga_state_t          phase_q, phase_d;
    logic [V_WIDTH-1:0] l_q, l_d;
    logic [H_WIDTH-1:0] s_q, s_d, h_q, h_d, htot_q, htot_d;
    logic               wrap, last_line;

    assign wrap       = s_q == htot_q;
    assign last_line  = phase_q == GA_STALL_LINES && wrap && l_q == V_WIDTH'(1);
    assign lines_done = last_line && h_q != '0;
    assign done       = (last_line && h_q == '0) || (phase_q == GA_STALL_SAMPLES && s_q == H_WIDTH'(1));
    assign busy       = phase_q != GA_IDLE;

    // Line phase walks S over 0..htot per line; the trailing sample phase counts S down to 1.
    always_comb begin
        phase_d = phase_q;
        l_d     = l_q;
        s_d     = s_q;
        h_d     = h_q;
        htot_d  = htot_q;
        if (abort) begin
            phase_d = GA_IDLE;
        end else if (load) begin
            l_d     = lines;
            s_d     = lines != '0 ? '0 : samples;
            h_d     = samples;
            htot_d  = htot;
            phase_d = lines != '0 ? GA_STALL_LINES : samples != '0 ? GA_STALL_SAMPLES : GA_IDLE;
        end else if (phase_q == GA_STALL_LINES) begin
            s_d     = lines_done ? h_q : wrap ? '0 : s_q + 1'b1;
            l_d     = wrap ? l_q - 1'b1 : l_q;
            phase_d = lines_done ? GA_STALL_SAMPLES : done ? GA_IDLE : GA_STALL_LINES;
        end else if (phase_q == GA_STALL_SAMPLES) begin
            s_d     = s_q - 1'b1;
            phase_d = done ? GA_IDLE : GA_STALL_SAMPLES;
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= GA_IDLE;
            l_q     <= '0;
            s_q     <= '0;
            h_q     <= '0;
            htot_q  <= '0;
        end else begin
            phase_q <= phase_d;
            l_q     <= l_d;
            s_q     <= s_d;
            h_q     <= h_d;
            htot_q  <= htot_d;
        end
    end

endmodule

// File: rtl/is2vid_genlock_adjust.sv
// is2vid_genlock_adjust: turns comparator genlock requests into frame-counter load/stall controls
module is2vid_genlock_adjust
    import is2vid_genlock_pkg::*;
#(
    parameter int H_WIDTH     = GA_H_WIDTH,
    parameter int V_WIDTH     = GA_V_WIDTH,
    parameter int MAX_H_STEP  = 16,
    parameter int LOCK_FRAMES = 3
) (
    input logic                    clk,
    input logic                    rst,
    is2vid_genlock_adjust_if.slave bus
);
    localparam logic [H_WIDTH-1:0]       MAX_STEP = H_WIDTH'(MAX_H_STEP);
    localparam logic [GA_LOCK_WIDTH-1:0] LOCK_MAX = GA_LOCK_WIDTH'(LOCK_FRAMES);

    ga_state_t                state_q, state_d;
    ga_req_t                  req;
    logic                     sof_q, sof_int, is_corr;
    logic [GA_LOCK_WIDTH-1:0] lock_q, lock_d;
    logic [H_WIDTH-1:0]       h_rst_q, h_rst_d, step, load_h;
    logic [V_WIDTH-1:0]       v_rst_q, v_rst_d, load_v;
    logic                     stall_load, stall_busy, lines_done, stall_done;
    logic                     cnt_enable_q, cnt_load_q, adjusting_q, locked_q;

    assign sof_int = bus.sof_cvo & ~sof_q;
    assign req     = ga_decode(bus.genlocked, bus.sync_lines, bus.sync_samples);
    assign is_corr = req == GA_REQ_LINES || req == GA_REQ_SAMPLES;
    assign step    = bus.sync_compare_h_reset > MAX_STEP ? MAX_STEP : bus.sync_compare_h_reset;
    // A sample-only request is a line request with zero lines and a capped sample step.
    assign load_h  = req == GA_REQ_LINES ? bus.sync_compare_h_reset : step;
    assign load_v  = req == GA_REQ_LINES ? bus.sync_compare_v_reset : '0;

    is2vid_stall_counter #(.H_WIDTH(H_WIDTH), .V_WIDTH(V_WIDTH)) u_stall (
        .clk        (clk),
        .rst        (rst),
        .abort      (!bus.enable),
        .load       (stall_load),
        .lines      (load_v),
        .samples    (load_h),
        .htot       (bus.h_total_minus_one),
        .busy       (stall_busy),
        .lines_done (lines_done),
        .done       (stall_done)
    );

    // Snapshot and decode at start-of-frame in IDLE; follow the stall counter otherwise.
    always_comb begin
        state_d    = state_q;
        lock_d     = lock_q;
        h_rst_d    = h_rst_q;
        v_rst_d    = v_rst_q;
        stall_load = 1'b0;
        case (state_q)
            GA_IDLE: begin
                if (sof_int && bus.enable) begin
                    lock_d = req == GA_REQ_LOCKED ? (lock_q == LOCK_MAX ? lock_q : lock_q + 1'b1)
                           : is_corr ? '0 : lock_q;
                    if (is_corr && bus.remove_repeatn && (load_h != '0 || load_v != '0)) begin
                        state_d = GA_LOAD;
                        h_rst_d = load_h;
                        v_rst_d = load_v;
                    end else if (is_corr && !bus.remove_repeatn) begin
                        stall_load = 1'b1;
                        state_d    = load_v != '0 ? GA_STALL_LINES : load_h != '0 ? GA_STALL_SAMPLES : GA_IDLE;
                    end
                end
            end
            GA_LOAD:          state_d = GA_IDLE;
            GA_STALL_LINES:   state_d = (stall_done || !stall_busy) ? GA_IDLE : lines_done ? GA_STALL_SAMPLES : GA_STALL_LINES;
            GA_STALL_SAMPLES: state_d = (stall_done || !stall_busy) ? GA_IDLE : GA_STALL_SAMPLES;
            default:          state_d = GA_IDLE;
        endcase
        if (!bus.enable) begin
            state_d = GA_IDLE;
            lock_d  = '0;
        end
    end

    // State, snapshot and registered outputs derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sof_q        <= 1'b0;
            state_q      <= GA_IDLE;
            lock_q       <= '0;
            h_rst_q      <= '0;
            v_rst_q      <= '0;
            cnt_enable_q <= 1'b1;
            cnt_load_q   <= 1'b0;
            adjusting_q  <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            sof_q        <= bus.sof_cvo;
            state_q      <= state_d;
            lock_q       <= lock_d;
            h_rst_q      <= h_rst_d;
            v_rst_q      <= v_rst_d;
            cnt_enable_q <= !(state_d == GA_STALL_LINES || state_d == GA_STALL_SAMPLES);
            cnt_load_q   <= state_d == GA_LOAD;
            adjusting_q  <= state_d != GA_IDLE;
            locked_q     <= lock_d == LOCK_MAX;
        end
    end

    assign bus.cnt_enable     = cnt_enable_q;
    assign bus.cnt_load       = cnt_load_q;
    assign bus.cnt_h_reset    = h_rst_q;
    assign bus.cnt_v_reset    = v_rst_q;
    assign bus.adjusting      = adjusting_q;
    assign bus.genlock_locked = locked_q;

endmodule

// File: tb/tb_is2vid_genlock_adjust.sv
// tb_is2vid_genlock_adjust: directed checks of lock debounce, loads, stalls and aborts
module tb_is2vid_genlock_adjust;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   n;

    is2vid_genlock_adjust_if bus ();

    is2vid_genlock_adjust dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Raise sof_cvo for one cycle; returns in cycle N+1 with sof_cvo low again.
    task automatic sof_edge();
        bus.sof_cvo = 1'b1;
        tick();
        bus.sof_cvo = 1'b0;
    endtask

    // Counts cnt_enable-low cycles over a fixed window, optionally pulsing sof_cvo at step sof_at.
    task automatic stall_window(input int sof_at, output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.cnt_enable === 1'b0) cnt++;
            bus.sof_cvo = (i == sof_at);
            tick();
        end
        bus.sof_cvo = 1'b0;
    endtask

    task automatic set_req(input logic gl, input logic ln, input logic sm, input logic rm,
                           input int h, input int v);
        bus.genlocked            = gl;
        bus.sync_lines           = ln;
        bus.sync_samples         = sm;
        bus.remove_repeatn       = rm;
        bus.sync_compare_h_reset = 14'(h);
        bus.sync_compare_v_reset = 13'(v);
    endtask

    initial begin
        bus.enable            = 1'b1;
        bus.sof_cvo           = 1'b0;
        bus.h_total_minus_one = 14'd9;
        set_req(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_cnt_enable", 32'(bus.cnt_enable), 1);
        chk("rst_cnt_load", 32'(bus.cnt_load), 0);
        chk("rst_h_reset", 32'(bus.cnt_h_reset), 0);
        chk("rst_v_reset", 32'(bus.cnt_v_reset), 0);
        chk("rst_adjusting", 32'(bus.adjusting), 0);
        chk("rst_locked", 32'(bus.genlock_locked), 0);
        rst = 1'b1;
        tick();

        // Lock debounce over three genlocked frames
        set_req(1, 0, 0, 0, 0, 0);
        sof_edge();
        chk("lock_after_1", 32'(bus.genlock_locked), 0);
        tick();
        sof_edge();
        chk("lock_after_2", 32'(bus.genlock_locked), 0);
        tick();
        sof_edge();
        chk("lock_after_3", 32'(bus.genlock_locked), 1);
        chk("lock_cnt_enable", 32'(bus.cnt_enable), 1);
        chk("lock_adjusting", 32'(bus.adjusting), 0);
        tick();
        sof_edge();
        chk("lock_saturated", 32'(bus.genlock_locked), 1);
        tick();

        // Line remove: one load pulse with both reset values
        set_req(0, 1, 0, 1, 100, 5);
        sof_edge();
        chk("ld_pulse", 32'(bus.cnt_load), 1);
        chk("ld_h", 32'(bus.cnt_h_reset), 100);
        chk("ld_v", 32'(bus.cnt_v_reset), 5);
        chk("ld_adjusting", 32'(bus.adjusting), 1);
        chk("ld_clears_lock", 32'(bus.genlock_locked), 0);
        tick();
        chk("ld_pulse_end", 32'(bus.cnt_load), 0);
        chk("ld_h_hold", 32'(bus.cnt_h_reset), 100);
        chk("ld_idle", 32'(bus.adjusting), 0);
        tick();

        // Line repeat: 2*(9+1)+3 = 23 stall cycles
        set_req(0, 1, 0, 0, 3, 2);
        sof_edge();
        chk("lr_first_stall", 32'(bus.cnt_enable), 0);
        chk("lr_adjusting", 32'(bus.adjusting), 1);
        stall_window(-1, n);
        chk("lr_len", 32'(n), 23);
        chk("lr_enable_back", 32'(bus.cnt_enable), 1);
        chk("lr_idle", 32'(bus.adjusting), 0);

        // Second start-of-frame during the stall is ignored
        sof_edge();
        stall_window(5, n);
        chk("b2b_len", 32'(n), 23);

        // Sample repeat capped at 16, then a zero-length request
        set_req(0, 0, 1, 0, 40, 0);
        sof_edge();
        stall_window(-1, n);
        chk("sr_len", 32'(n), 16);
        set_req(0, 0, 1, 0, 0, 0);
        sof_edge();
        chk("sr0_adjusting", 32'(bus.adjusting), 0);
        chk("sr0_cnt_enable", 32'(bus.cnt_enable), 1);
        tick();

        // Sample remove loads the capped step with zero lines
        set_req(0, 0, 1, 1, 40, 7);
        sof_edge();
        chk("sm_pulse", 32'(bus.cnt_load), 1);
        chk("sm_h", 32'(bus.cnt_h_reset), 16);
        chk("sm_v", 32'(bus.cnt_v_reset), 0);
        tick();

        // Zero-length line remove is skipped and keeps old reset values
        set_req(0, 1, 0, 1, 0, 0);
        sof_edge();
        chk("z_no_load", 32'(bus.cnt_load), 0);
        chk("z_idle", 32'(bus.adjusting), 0);
        chk("z_h_hold", 32'(bus.cnt_h_reset), 16);
        tick();

        // Enable low clears a reached lock
        set_req(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            sof_edge();
            tick();
        end
        chk("en_locked_before", 32'(bus.genlock_locked), 1);
        bus.enable = 1'b0;
        tick();
        chk("en_lock_cleared", 32'(bus.genlock_locked), 0);
        bus.enable = 1'b1;
        tick();

        // Enable low five cycles into a 23-cycle stall aborts it
        set_req(0, 1, 0, 0, 3, 2);
        sof_edge();
        for (int i = 0; i < 4; i++) tick();
        chk("ab_in_stall", 32'(bus.cnt_enable), 0);
        bus.enable = 1'b0;
        tick();
        chk("ab_cnt_enable", 32'(bus.cnt_enable), 1);
        chk("ab_idle", 32'(bus.adjusting), 0);
        chk("ab_locked", 32'(bus.genlock_locked), 0);
        bus.enable = 1'b1;
        tick();
        tick();
        chk("ab_stays_idle", 32'(bus.cnt_enable), 1);

        // Asynchronous reset mid-stall
        sof_edge();
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("ar_cnt_enable", 32'(bus.cnt_enable), 1);
        chk("ar_adjusting", 32'(bus.adjusting), 0);
        chk("ar_h_reset", 32'(bus.cnt_h_reset), 0);
        tick();
        rst = 1'b1;
        tick();
        chk("ar_after", 32'(bus.cnt_enable), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/is2vid_genlock_adjust.md
# is2vid_genlock_adjust

Applies the genlock corrections requested by the IS2Vid sync comparator to the CVO output frame counter. It sits directly downstream of the comparator and consumes its `sync_lines`, `sync_samples`, `remove_repeatn`, `sync_compare_h_reset`, `sync_compare_v_reset` and `genlocked` outputs. At each CVO start-of-frame it snapshots the request and turns it into one of two counter controls:

- a one-cycle counter load, which jumps ahead (remove);
- a counter-enable stall of exact length (repeat).

It also reports a debounced lock status.

## Interface
Parameters:
- `H_WIDTH`, default 14: width of the horizontal count and reset values.
- `V_WIDTH`, default 13: width of the vertical count and reset values.
- `MAX_H_STEP`, default 16: largest sample-only correction applied per frame.
- `LOCK_FRAMES`, default 3: number of consecutive genlocked frames required before `genlock_locked` rises. Range 1..15.

Ports (clock and reset first):
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset; asynchronous, active-low.
- `enable`  in  1  genlock correction enabled; a low level aborts any correction in progress.
- `sof_cvo`  in  1  CVO start-of-frame level; the block edge-detects it internally.
- `h_total_minus_one`  in  H_WIDTH  output line length minus one.
- `sync_lines`, `sync_samples`, `remove_repeatn`, `genlocked`  in  1 each  comparator request flags.
- `sync_compare_h_reset`  in  H_WIDTH  sample offset from the comparator.
- `sync_compare_v_reset`  in  V_WIDTH  line offset from the comparator.
- `cnt_enable`  out  1  frame counter advance enable.
- `cnt_load`  out  1  one-cycle pulse that loads the frame counter.
- `cnt_h_reset`  out  H_WIDTH  horizontal value loaded with `cnt_load`.
- `cnt_v_reset`  out  V_WIDTH  vertical value loaded with `cnt_load`.
- `adjusting`  out  1  high while the block is in any non-IDLE state.
- `genlock_locked`  out  1  debounced lock status.

## Operation
- Edge detect: `sof_q` is registered. `sof_int = sof_cvo & ~sof_q`. `sof_q` resets to 0.
- States: IDLE, LOAD, STALL_LINES, STALL_SAMPLES.
- Snapshot: on `sof_int` in IDLE with `enable` high, the block captures `h = sync_compare_h_reset`, `v = sync_compare_v_reset`, `htot = h_total_minus_one` and the request flags, then decides:
  - `genlocked` = 1: no correction. `lock_cnt` increments, saturating at LOCK_FRAMES.
  - `sync_lines` = 1 and `remove_repeatn` = 1: go to LOAD with `cnt_h_reset = h`, `cnt_v_reset = v`.
  - `sync_lines` = 1 and `remove_repeatn` = 0: go to STALL_LINES with line counter `L = v` and sample counter `S = 0`.
  - `sync_samples` only: `step = min(h, MAX_H_STEP)`.
    - `remove_repeatn` = 1: go to LOAD with `cnt_h_reset = step`, `cnt_v_reset = 0`.
    - `remove_repeatn` = 0: go to STALL_SAMPLES with `S = step`.
  - No flag set: stay in IDLE.
- Lock counter: any correction clears `lock_cnt`. `genlock_locked = (lock_cnt == LOCK_FRAMES)`.
- LOAD: lasts one cycle with `cnt_load` = 1, then returns to IDLE.
- STALL_LINES:
  - `cnt_enable` = 0.
  - S counts 0..htot. When it wraps, L decrements.
  - On the wrap where L = 1: go to STALL_SAMPLES with `S = h` if h > 0, otherwise go to IDLE.
- STALL_SAMPLES: `cnt_enable` = 0. S decrements each cycle; leave for IDLE in the cycle S = 1.
- Total stall length: exactly `v*(htot+1) + h` cycles for a line stall, or `step` cycles for a sample stall.
- Zero-length requests: a STALL_SAMPLES entry with S = 0, or a LOAD with h = v = 0, is skipped and the block stays in IDLE.
- `sof_int` outside IDLE is ignored. It takes no snapshot and does not change `lock_cnt`.
- `enable` low in any state:
  - next cycle: state IDLE, `cnt_enable` = 1, `cnt_load` = 0;
  - `lock_cnt` = 0.
- Arithmetic is unsigned and never wraps. `min` uses an H_WIDTH compare. L and S are V_WIDTH and H_WIDTH wide respectively.

## Timing
- Reset values: `cnt_enable` = 1; `cnt_load` = 0; `cnt_h_reset` = 0; `cnt_v_reset` = 0; `adjusting` = 0; `genlock_locked` = 0; state IDLE; `lock_cnt` = 0.
- All outputs are registered.
- Latency: if `sof_cvo` rises in cycle N, then `cnt_load` or the first `cnt_enable` = 0 appears in cycle N+1.
- `cnt_h_reset` and `cnt_v_reset` are valid in the `cnt_load` cycle and hold their values until the next load.
- `genlock_locked` updates in cycle N+1.
- `cnt_enable` returns to 1 in the cycle after the last stall cycle.
- Back-to-back: a new `sof_int` is honoured in the first IDLE cycle.
- Reset asserted mid-stall: outputs take their reset values immediately (asynchronous).

## Structure
- Shared package `is2vid_genlock_pkg`:
  - state enum `ga_state_t`;
  - width constants `GA_H_WIDTH` and `GA_V_WIDTH`;
  - request-decode constants.
- Sub-module `is2vid_stall_counter` holds the nested L/S counters:
  - inputs: load, lines, samples, htot;
  - outputs: busy, done pulse.

## Test plan
1. Reset, then `sof_cvo` pulses with `genlocked` = 1 and LOCK_FRAMES = 3 → `genlock_locked` rises one cycle after the 3rd edge; `cnt_enable` stays 1.
2. `sync_lines` = 1, `remove_repeatn` = 1, h = 100, v = 5 → exactly one `cnt_load` pulse in cycle N+1 with `cnt_h_reset` = 100, `cnt_v_reset` = 5.
3. Line repeat with htot = 9, v = 2, h = 3 → `cnt_enable` low for exactly 23 consecutive cycles.
4. Sample repeat with h = 40, MAX_H_STEP = 16 → 16 stall cycles. Then h = 0 → no stall and `adjusting` stays 0.
5. `enable` dropped 5 cycles into a 23-cycle stall → `cnt_enable` = 1 the next cycle, state IDLE, `genlock_locked` = 0.
6. Second `sof_cvo` edge arriving during a stall → ignored; stall length unchanged.
